// File: rtl/sprite_pkg.sv
// Shared types and screen defaults for the sprite blitter and the scanline renderer.
package sprite_pkg;

    localparam int unsigned CORDW_DEF = 16;
    localparam int unsigned H_RES_DEF = 640;
    localparam int unsigned V_RES_DEF = 480;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        LATCH   = 3'd2,
        WRITE   = 3'd3,
        ADVANCE = 3'd4,
        DONE    = 3'd5
    } blit_state_t;

    typedef logic signed [CORDW_DEF-1:0] coord_t;

    // Counter width that stays legal when the range collapses to a single value.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_walk_ctr.sv
// Scaled raster walk over a WIDTH x HEIGHT source: destination offsets plus
// an incrementally maintained source address (optionally column-mirrored).
module sprite_walk_ctr
    import sprite_pkg::*;
#(
    parameter int unsigned WIDTH  = 10,
    parameter int unsigned HEIGHT = 10,
    parameter int unsigned SCALE  = 1,
    parameter int unsigned DW     = 16,
    parameter int unsigned AW     = clog2_min1(WIDTH * HEIGHT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          step,
    input  logic          mirror,
    output logic [DW-1:0] dx,
    output logic [DW-1:0] dy,
    output logic [AW-1:0] src_addr,
    output logic          last
);

    localparam int unsigned OXW = clog2_min1(WIDTH);
    localparam int unsigned OYW = clog2_min1(HEIGHT);
    localparam int unsigned SW  = clog2_min1(SCALE);

    logic [OXW-1:0] ox, ox_d;
    logic [OYW-1:0] oy, oy_d;
    logic [SW-1:0]  cnt_x, cnt_x_d, cnt_y, cnt_y_d;
    logic [DW-1:0]  dx_d, dy_d;
    logic [AW-1:0]  addr_d;
    logic           last_d;

    // Next walk position; the address moves by +-1 per column and rewinds a row on repeats.
    always_comb begin
        ox_d    = ox;
        oy_d    = oy;
        cnt_x_d = cnt_x;
        cnt_y_d = cnt_y;
        dx_d    = dx;
        dy_d    = dy;
        addr_d  = src_addr;
        if (clear) begin
            ox_d    = '0;
            oy_d    = '0;
            cnt_x_d = '0;
            cnt_y_d = '0;
            dx_d    = '0;
            dy_d    = '0;
            addr_d  = mirror ? AW'(WIDTH - 1) : '0;
        end else if (step) begin
            if (cnt_x != SW'(SCALE - 1)) begin
                cnt_x_d = cnt_x + SW'(1);
                dx_d    = dx + DW'(1);
            end else begin
                cnt_x_d = '0;
                if (ox != OXW'(WIDTH - 1)) begin
                    ox_d   = ox + OXW'(1);
                    dx_d   = dx + DW'(1);
                    addr_d = mirror ? src_addr - AW'(1) : src_addr + AW'(1);
                end else begin
                    ox_d = '0;
                    dx_d = '0;
                    dy_d = dy + DW'(1);
                    if (cnt_y != SW'(SCALE - 1)) begin
                        cnt_y_d = cnt_y + SW'(1);
                        addr_d  = mirror ? src_addr + AW'(WIDTH - 1) : src_addr - AW'(WIDTH - 1);
                    end else begin
                        cnt_y_d = '0;
                        oy_d    = oy + OYW'(1);
                        addr_d  = mirror ? src_addr + AW'(2 * WIDTH - 1) : src_addr + AW'(1);
                    end
                end
            end
        end
        last_d = (ox_d == OXW'(WIDTH - 1)) && (cnt_x_d == SW'(SCALE - 1)) &&
                 (oy_d == OYW'(HEIGHT - 1)) && (cnt_y_d == SW'(SCALE - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ox       <= '0;
            oy       <= '0;
            cnt_x    <= '0;
            cnt_y    <= '0;
            dx       <= '0;
            dy       <= '0;
            src_addr <= '0;
            last     <= 1'b0;
        end else begin
            ox       <= ox_d;
            oy       <= oy_d;
            cnt_x    <= cnt_x_d;
            cnt_y    <= cnt_y_d;
            dx       <= dx_d;
            dy       <= dy_d;
            src_addr <= addr_d;
            last     <= last_d;
        end
    end

endmodule

// File: rtl/sprite_blit.sv
// Copies one sprite from a sync ROM into the framebuffer with scaling,
// transparency skip and edge clipping. SPRITE_BLIT_MIRROR_EN adds mirror_x.
module sprite_blit
    import sprite_pkg::*;
#(
    parameter int unsigned WIDTH           = 10,
    parameter int unsigned HEIGHT          = 10,
    parameter int unsigned SCALE           = 1,
    parameter int unsigned COLR_BITS       = 12,
    parameter int unsigned CORDW           = CORDW_DEF,
    parameter int unsigned H_RES           = H_RES_DEF,
    parameter int unsigned V_RES           = V_RES_DEF,
    parameter int unsigned TRANSPARENT_VAL = 0,
    parameter int unsigned FB_ADDRW        = $clog2(H_RES * V_RES)
) (
    input  logic                                   clk_pix,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic signed [CORDW-1:0]                sprx,
    input  logic signed [CORDW-1:0]                spry,
`ifdef SPRITE_BLIT_MIRROR_EN
    input  logic                                   mirror_x,
`endif
    output logic                                   busy,
    output logic                                   done,
    output logic [clog2_min1(WIDTH*HEIGHT)-1:0]    rom_addr,
    input  logic [COLR_BITS-1:0]                   rom_data,
    output logic [FB_ADDRW-1:0]                    fb_addr,
    output logic [COLR_BITS-1:0]                   fb_data,
    output logic                                   fb_we,
    input  logic                                   fb_ready
);

    localparam int unsigned             ROM_AW = clog2_min1(WIDTH * HEIGHT);
    localparam logic signed [CORDW-1:0] H_LIM  = CORDW'(H_RES);
    localparam logic signed [CORDW-1:0] V_LIM  = CORDW'(V_RES);

    blit_state_t state, state_d;

    logic signed [CORDW-1:0] sprx_q, spry_q, pix_x, pix_y;
    logic [CORDW-1:0]        dx, dy;
    logic                    walk_clear, walk_step, walk_last, mirror_eff;
    logic                    start_acc, on_screen, opaque;
    logic [FB_ADDRW-1:0]     pix_addr;
    logic                    busy_d, done_d, fb_we_d;
    logic [FB_ADDRW-1:0]     fb_addr_d;
    logic [COLR_BITS-1:0]    fb_data_d;

    assign start_acc = (state == IDLE) && start;

`ifdef SPRITE_BLIT_MIRROR_EN
    logic mirror_q;

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n)         mirror_q <= 1'b0;
        else if (start_acc) mirror_q <= mirror_x;
    end

    // The walker is cleared on the accepting edge, before mirror_q is loaded.
    assign mirror_eff = start_acc ? mirror_x : mirror_q;
`else
    assign mirror_eff = 1'b0;
`endif

    sprite_walk_ctr #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .SCALE  (SCALE),
        .DW     (CORDW),
        .AW     (ROM_AW)
    ) u_walk (
        .clk      (clk_pix),
        .rst_n    (rst_n),
        .clear    (walk_clear),
        .step     (walk_step),
        .mirror   (mirror_eff),
        .dx       (dx),
        .dy       (dy),
        .src_addr (rom_addr),
        .last     (walk_last)
    );

    // Screen position and clipping for the pixel currently being fetched.
    assign pix_x     = sprx_q + $signed(dx);
    assign pix_y     = spry_q + $signed(dy);
    assign on_screen = !pix_x[CORDW-1] && (pix_x < H_LIM) &&
                       !pix_y[CORDW-1] && (pix_y < V_LIM);
    assign opaque    = (rom_data != COLR_BITS'(TRANSPARENT_VAL));
    assign pix_addr  = FB_ADDRW'(FB_ADDRW'(pix_y) * FB_ADDRW'(H_RES) + FB_ADDRW'(pix_x));

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d    = state;
        busy_d     = busy;
        done_d     = 1'b0;
        fb_we_d    = fb_we;
        fb_addr_d  = fb_addr;
        fb_data_d  = fb_data;
        walk_clear = 1'b0;
        walk_step  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    walk_clear = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = FETCH;
                end
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                fb_data_d = rom_data;
                if (on_screen && opaque) begin
                    fb_addr_d = pix_addr;
                    fb_we_d   = 1'b1;
                    state_d   = WRITE;
                end else begin
                    state_d = ADVANCE;
                end
            end
            WRITE: begin
                if (fb_ready) begin
                    fb_we_d = 1'b0;
                    state_d = ADVANCE;
                end
            end
            ADVANCE: begin
                if (walk_last) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    walk_step = 1'b1;
                    state_d   = FETCH;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                fb_we_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            fb_we   <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
            sprx_q  <= '0;
            spry_q  <= '0;
        end else begin
            busy    <= busy_d;
            done    <= done_d;
            fb_we   <= fb_we_d;
            fb_addr <= fb_addr_d;
            fb_data <= fb_data_d;
            if (start_acc) begin
                sprx_q <= sprx;
                spry_q <= spry;
            end
        end
    end

endmodule

// File: tb/tb_sprite_blit.sv
// Scoreboard bench for sprite_blit: a 4x2 unscaled instance and a 2x2 SCALE=2 instance.
module tb_sprite_blit;
    import sprite_pkg::*;

    localparam int unsigned FBW = 19;

    typedef struct packed {
        logic [FBW-1:0] addr;
        logic [11:0]    data;
    } wr_t;

    logic clk_pix = 1'b0;
    always #5 clk_pix = ~clk_pix;

    logic rst_n;

    logic           start_a, busy_a, done_a, fb_we_a, fb_ready_a;
    coord_t         sprx_a, spry_a;
    logic [2:0]     rom_addr_a;
    logic [11:0]    rom_data_a, fb_data_a;
    logic [FBW-1:0] fb_addr_a;
    logic [11:0]    rom_a [8];

    logic           start_b, busy_b, done_b, fb_we_b, fb_ready_b;
    coord_t         sprx_b, spry_b;
    logic [1:0]     rom_addr_b;
    logic [11:0]    rom_data_b, fb_data_b;
    logic [FBW-1:0] fb_addr_b;
    logic [11:0]    rom_b [4];

    wr_t exp_a[$], exp_b[$];
    wr_t ea, eb;
    int  n_vec = 0, n_err = 0;
    int  wr_a = 0, wr_b = 0, dn_a = 0, dn_b = 0;

    int t1  [8]  = '{12810, 12811, 12812, 12813, 13450, 13451, 13452, 13453};
    int t3  [4]  = '{0, 1, 640, 641};
    int t4a [16] = '{0, 1, 2, 3, 640, 641, 642, 643, 1280, 1281, 1282, 1283, 1920, 1921, 1922, 1923};
    int t4d [16] = '{1, 1, 2, 2, 1, 1, 2, 2, 3, 3, 4, 4, 3, 3, 4, 4};

    sprite_blit #(.WIDTH(4), .HEIGHT(2), .SCALE(1)) u_a (
        .clk_pix (clk_pix), .rst_n (rst_n), .start (start_a),
        .sprx (sprx_a), .spry (spry_a),
`ifdef SPRITE_BLIT_MIRROR_EN
        .mirror_x (1'b0),
`endif
        .busy (busy_a), .done (done_a),
        .rom_addr (rom_addr_a), .rom_data (rom_data_a),
        .fb_addr (fb_addr_a), .fb_data (fb_data_a), .fb_we (fb_we_a), .fb_ready (fb_ready_a)
    );

    sprite_blit #(.WIDTH(2), .HEIGHT(2), .SCALE(2)) u_b (
        .clk_pix (clk_pix), .rst_n (rst_n), .start (start_b),
        .sprx (sprx_b), .spry (spry_b),
`ifdef SPRITE_BLIT_MIRROR_EN
        .mirror_x (1'b0),
`endif
        .busy (busy_b), .done (done_b),
        .rom_addr (rom_addr_b), .rom_data (rom_data_b),
        .fb_addr (fb_addr_b), .fb_data (fb_data_b), .fb_we (fb_we_b), .fb_ready (fb_ready_b)
    );

    // Synchronous sprite ROMs: data one cycle after address.
    always @(posedge clk_pix) begin
        rom_data_a <= rom_a[rom_addr_a];
        rom_data_b <= rom_b[rom_addr_b];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input bit sel, input int addr, input logic [11:0] data);
        wr_t e;
        e.addr = FBW'(addr);
        e.data = data;
        if (sel) exp_b.push_back(e);
        else     exp_a.push_back(e);
    endtask

    // Monitor: each accepted write is popped from its scoreboard and compared.
    always @(negedge clk_pix) begin
        if (rst_n) begin
            if (fb_we_a && fb_ready_a) begin
                if (exp_a.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL wr_a_extra: got write addr %0d data %h, expected none", fb_addr_a, fb_data_a);
                end else begin
                    ea = exp_a.pop_front();
                    check("wr_a_addr", 32'(fb_addr_a), 32'(ea.addr));
                    check("wr_a_data", 32'(fb_data_a), 32'(ea.data));
                end
                wr_a++;
            end
            if (fb_we_b && fb_ready_b) begin
                if (exp_b.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL wr_b_extra: got write addr %0d data %h, expected none", fb_addr_b, fb_data_b);
                end else begin
                    eb = exp_b.pop_front();
                    check("wr_b_addr", 32'(fb_addr_b), 32'(eb.addr));
                    check("wr_b_data", 32'(fb_data_b), 32'(eb.data));
                end
                wr_b++;
            end
            if (done_a) dn_a++;
            if (done_b) dn_b++;
        end
    end

    task automatic run(input bit sel, input coord_t sx, input coord_t sy, input int nexp);
        int w0, d0, n;
        w0 = sel ? wr_b : wr_a;
        d0 = sel ? dn_b : dn_a;
        @(posedge clk_pix); #1;
        if (sel) begin sprx_b = sx; spry_b = sy; start_b = 1'b1; end
        else     begin sprx_a = sx; spry_a = sy; start_a = 1'b1; end
        @(posedge clk_pix); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        n = 0;
        while ((sel ? dn_b : dn_a) == d0 && n < 1000) begin
            @(negedge clk_pix);
            n++;
        end
        repeat (3) @(posedge clk_pix);
        #1;
        check("done_pulses", 32'((sel ? dn_b : dn_a) - d0), 32'd1);
        check("write_count", 32'((sel ? wr_b : wr_a) - w0), 32'(nexp));
        check("busy_after",  32'(sel ? busy_b : busy_a), 32'd0);
        check("done_low",    32'(sel ? done_b : done_a), 32'd0);
        check("sb_empty",    32'(sel ? exp_b.size() : exp_a.size()), 32'd0);
    endtask

    initial begin
        int n, w0;
        rst_n = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        sprx_a = '0; spry_a = '0; sprx_b = '0; spry_b = '0;
        fb_ready_a = 1'b1; fb_ready_b = 1'b1;
        for (int i = 0; i < 8; i++) rom_a[i] = 12'hF00;
        for (int i = 0; i < 4; i++) rom_b[i] = 12'(i + 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy",     32'(busy_a),     32'd0);
        check("rst_done",     32'(done_a),     32'd0);
        check("rst_fb_we",    32'(fb_we_a),    32'd0);
        check("rst_rom_addr", 32'(rom_addr_a), 32'd0);
        check("rst_fb_addr",  32'(fb_addr_a),  32'd0);
        check("rst_fb_data",  32'(fb_data_a),  32'd0);
        #20 rst_n = 1'b1;

        // Plain 4x2 blit at (10,20).
        for (int i = 0; i < 8; i++) push(0, t1[i], 12'hF00);
        run(0, 16'sd10, 16'sd20, 8);

        // Transparent source word 1 leaves 12811 untouched.
        rom_a[1] = 12'h000;
        for (int i = 0; i < 8; i++) if (i != 1) push(0, t1[i], 12'hF00);
        run(0, 16'sd10, 16'sd20, 7);
        rom_a[1] = 12'hF00;

        // Left-edge clip.
        for (int i = 0; i < 4; i++) push(0, t3[i], 12'hF00);
        run(0, -16'sd2, 16'sd0, 4);

        // Scale 2: data encodes the source address walk 0,0,1,1,0,0,1,1,2,2,3,3,2,2,3,3.
        for (int i = 0; i < 16; i++) push(1, t4a[i], 12'(t4d[i]));
        run(1, 16'sd0, 16'sd0, 16);

        // Back-pressure: first write held off for 5 cycles.
        fb_ready_a = 1'b0;
        for (int i = 0; i < 8; i++) push(0, t1[i], 12'hF00);
        fork
            run(0, 16'sd10, 16'sd20, 8);
            begin
                n = 0;
                while (!fb_we_a && n < 100) begin
                    @(negedge clk_pix);
                    n++;
                end
                for (int i = 0; i < 5; i++) begin
                    check("bp_we",   32'(fb_we_a),   32'd1);
                    check("bp_addr", 32'(fb_addr_a), 32'd12810);
                    check("bp_data", 32'(fb_data_a), 32'h0F00);
                    if (i < 4) @(negedge clk_pix);
                end
                @(posedge clk_pix); #1;
                fb_ready_a = 1'b1;
            end
        join

        // Reset asserted between clock edges while the third write is pending.
        for (int i = 0; i < 8; i++) push(0, t1[i], 12'hF00);
        w0 = wr_a;
        @(posedge clk_pix); #1;
        sprx_a = 16'sd10; spry_a = 16'sd20; start_a = 1'b1;
        @(posedge clk_pix); #1;
        start_a = 1'b0;
        n = 0;
        while ((wr_a - w0) < 2 && n < 200) begin
            @(negedge clk_pix);
            n++;
        end
        @(posedge clk_pix); #1;
        fb_ready_a = 1'b0;
        n = 0;
        while (!fb_we_a && n < 50) begin
            @(negedge clk_pix);
            n++;
        end
        check("rst3_pre_we",   32'(fb_we_a),   32'd1);
        check("rst3_pre_addr", 32'(fb_addr_a), 32'd12812);
        #2 rst_n = 1'b0;
        #1;
        check("rst3_we",    32'(fb_we_a),   32'd0);
        check("rst3_busy",  32'(busy_a),    32'd0);
        check("rst3_state", 32'(u_a.state), 32'(IDLE));
        exp_a.delete();
        repeat (2) @(posedge clk_pix);
        #1;
        fb_ready_a = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) push(0, t1[i], 12'hF00);
        run(0, 16'sd10, 16'sd20, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
